multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle control FSM for the MIPS datapath, replacing the original fixed controller. It decodes `Op`/`Func` across FETCH/DECODE/execute/writeback states and drives all datapath select and write-enable lines. It adds a synchronous reset and an optional memory ready handshake. It also decodes immediate logic ops and traps illegal opcodes. All outputs are Moore outputs, fully assigned in every state.

## Interface
- `MEM_HANDSHAKE`, 1: 1 = FETCH/MEMRD/MEMWR wait for `MemReady`; 0 = `MemReady` ignored and treated as 1.
- `ILLEGAL_HALT`, 1: 1 = TRAP holds until reset; 0 = TRAP returns to FETCH after one cycle.
- `Clk` in 1: the only clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `Op` in 6: instruction opcode from IR. `Func` in 6: IR[5:0].
- `MemReady` in 1: memory access completes this cycle.
- `PCWrite`, `IRWrite`, `MemRead`, `MemWrite`, `RegWrite` out 1: write/read enables.
- `IorD`, `ALUSrcA`, `Branch`, `BranchNe`, `Illegal` out 1.
- `ALUSrcB`, `ALUOp`, `RegDst`, `MemtoReg` out 2.
- `PCSrc` out 3: 0 = ALU, 1 = branch target, 2 = jump target, 4 = register (rs).
- `State` out 5: current state code, for debug.

## Operation
- Default for every output in every state is 0; only the values listed below differ.
- Decode table:
  - FETCH(0): `MemRead`=1, `ALUSrcB`=01, `IRWrite`=`PCWrite`=rdy. Holds while !rdy; goes to DECODE when rdy.
  - DECODE(1): `ALUSrcB`=11. Next state by instruction:
    - R-type (Op 000000): Func 001000 (jr) -> JR; Func 001001 (jalr) -> JALR_LINK; any other Func -> EXEC.
    - lw 100011 and sw 101011 -> MEMADR.
    - beq 000100 and bne 000101 -> BRANCH.
    - addi 001000, andi 001100, ori 001101, slti 001010 -> IEXEC.
    - j 000010 -> JUMP; jal 000011 -> JAL_LINK.
    - Any other Op -> TRAP.
- MEMADR(2): `ALUSrcA`=1, `ALUSrcB`=10. lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): `IorD`=1, `MemRead`=1. Holds while !rdy, then -> MEMWB.
- MEMWB(4): `RegWrite`=1, `MemtoReg`=01, `RegDst`=00 -> FETCH.
- MEMWR(5): `IorD`=1, `MemWrite`=1. Holds while !rdy, then -> FETCH. `MemWrite` stays asserted for every hold cycle.
- EXEC(6): `ALUSrcA`=1, `ALUOp`=10 -> ALUWB.
- ALUWB(7): `RegWrite`=1, `RegDst`=01 -> FETCH.
- BRANCH(8): `ALUSrcA`=1, `ALUOp`=01, `PCSrc`=1, `Branch`=1, `BranchNe`=(Op==000101) -> FETCH.
- IEXEC(9): `ALUSrcA`=1, `ALUSrcB`=10. `ALUOp`=00 for addi, 11 otherwise (the ALU decoder resolves by Op) -> IWB.
- IWB(10): `RegWrite`=1, `RegDst`=00 -> FETCH.
- JUMP(11): `PCWrite`=1, `PCSrc`=2 -> FETCH.
- JR(12): `PCWrite`=1, `PCSrc`=4 -> FETCH.
- JALR_LINK(13): `RegWrite`=1, `RegDst`=01, `MemtoReg`=10 -> JR.
- JAL_LINK(14): `RegWrite`=1, `RegDst`=10, `MemtoReg`=10 -> JUMP.
- TRAP(15): `Illegal`=1. Stays if `ILLEGAL_HALT`=1; otherwise -> FETCH.
- rdy = `MEM_HANDSHAKE` ? `MemReady` : 1.
- The link is written before the PC changes, so the link register receives PC+4 (already incremented in FETCH).
- `BranchNe` replaces the old level-held branch flag. It is combinational from state and Op, with no delay.

## Timing
- Reset: on a rising edge with `Reset`=1, `State` becomes FETCH (0). This applies from any state, including mid-memory wait or TRAP.
- While `Reset`=1, `PCWrite`, `IRWrite`, `MemRead`, `MemWrite`, `RegWrite` and `Illegal` are forced to 0. All other outputs are 0.
- Outputs depend only on registered `State` plus `Op` and rdy; there is no delay statement anywhere.
- Latency in cycles with rdy=1:
  - lw 5; sw 4; R-type 4; immediate ops 4; beq/bne 3.
  - j 3; jal 4; jr 3; jalr 4.
- Each cycle with rdy=0 in FETCH, MEMRD or MEMWR adds one cycle.
- The IR is held stable from DECODE onward, because `IRWrite` is asserted only in FETCH with rdy.
- With `MEM_HANDSHAKE`=0, `MemReady`=X must not propagate to any output.

## Test plan
- Reset held 2 cycles mid-MEMRD, then released -> `State`=0 on the next edge. All enables stay 0 during reset, and the first post-reset cycle shows `MemRead`=1.
- lw (Op 100011), `MemReady` low 2 cycles in MEMRD -> state sequence 0,1,2,3,3,3,4,0. `RegWrite`=1 and `MemtoReg`=01 only in state 4.
- bne (Op 000101) -> states 0,1,8,0. In state 8: `Branch`=1, `BranchNe`=1, `PCSrc`=1, `ALUOp`=01. beq gives the same sequence with `BranchNe`=0.
- jal then jalr (Op 000000, Func 001001):
  - jal -> 0,1,14,11,0 with `RegDst`=10 in state 14.
  - jalr -> 0,1,13,12,0 with `PCSrc`=4 in state 12.
- ori (Op 001101) -> `ALUOp`=11 and `ALUSrcB`=10 in state 9. addi (001000) -> `ALUOp`=00 in state 9.
- Op 111111:
  - `ILLEGAL_HALT`=1 -> `Illegal`=1 every cycle until reset.
  - `ILLEGAL_HALT`=0 -> `Illegal` pulses 1 cycle, then state returns to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle control FSM for the MIPS datapath. It decodes Op/Func across
//   FETCH, DECODE, execute and writeback states and drives every datapath
//   select and write-enable line as a Moore output of the registered state.
//   Op and the memory-ready handshake qualify a few of those outputs.
//   Illegal opcodes are trapped in the TRAP state.
//
// Parameters
//   MEM_HANDSHAKE : 1 = FETCH/MEMRD/MEMWR wait for MemReady, 0 = never wait
//   ILLEGAL_HALT  : 1 = TRAP holds until reset, 0 = TRAP lasts one cycle
//
// Ports
//   Clk       in  1  clock, rising edge
//   Reset     in  1  synchronous active-high reset
//   Op        in  6  opcode from IR
//   Func      in  6  IR[5:0]
//   MemReady  in  1  memory access completes this cycle
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite   out 1  enables
//   IorD, ALUSrcA, Branch, BranchNe, Illegal        out 1  selects/flags
//   ALUSrcB, ALUOp, RegDst, MemtoReg                out 2  selects
//   PCSrc     out 3  0 ALU, 1 branch target, 2 jump target, 4 rs
//   State     out 5  current state code (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_HALT  = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       BranchNe,
  output logic       Illegal,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [2:0] PCSrc,
  output logic [4:0] State
);

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_MEMADR    = 5'd2,
    S_MEMRD     = 5'd3,
    S_MEMWB     = 5'd4,
    S_MEMWR     = 5'd5,
    S_EXEC      = 5'd6,
    S_ALUWB     = 5'd7,
    S_BRANCH    = 5'd8,
    S_IEXEC     = 5'd9,
    S_IWB       = 5'd10,
    S_JUMP      = 5'd11,
    S_JR        = 5'd12,
    S_JALR_LINK = 5'd13,
    S_JAL_LINK  = 5'd14,
    S_TRAP      = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  state_t state_q, state_d;

  // Without the handshake MemReady is never looked at, so an X on it
  // cannot reach any output.
  logic rdy;
  assign rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_RTYPE: begin
            if (Func == FN_JR)        state_d = S_JR;
            else if (Func == FN_JALR) state_d = S_JALR_LINK;
            else                      state_d = S_EXEC;
          end
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JAL_LINK;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:    state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:     if (rdy) state_d = S_MEMWB;
      S_MEMWB:     state_d = S_FETCH;
      S_MEMWR:     if (rdy) state_d = S_FETCH;
      S_EXEC:      state_d = S_ALUWB;
      S_ALUWB:     state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_IEXEC:     state_d = S_IWB;
      S_IWB:       state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_JR:        state_d = S_FETCH;
      // Link is written first, then the PC moves, so the link gets PC+4.
      S_JALR_LINK: state_d = S_JR;
      S_JAL_LINK:  state_d = S_JUMP;
      S_TRAP:      state_d = ILLEGAL_HALT ? S_TRAP : S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore outputs (ungated)
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       iord, alu_src_a, branch, branch_ne, illegal;
  logic [1:0] alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic [2:0] pc_src;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    illegal    = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    pc_src     = 3'd0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC update only on the cycle the fetch completes, which
        // keeps the IR stable from DECODE onward.
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 3'd1;
        branch    = 1'b1;
        branch_ne = (Op == OP_BNE);
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // 11 hands the logic/compare immediates to the ALU decoder by Op.
        alu_op    = (Op == OP_ADDI) ? 2'b00 : 2'b11;
      end
      S_IWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 3'd2;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = 3'd4;
      end
      S_JALR_LINK: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        mem_to_reg = 2'b10;
      end
      S_JAL_LINK: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // Everything reads as zero while Reset is held, whatever the state.
  logic run;
  assign run = ~Reset;

  assign PCWrite  = run & pc_write;
  assign IRWrite  = run & ir_write;
  assign MemRead  = run & mem_read;
  assign MemWrite = run & mem_write;
  assign RegWrite = run & reg_write;
  assign IorD     = run & iord;
  assign ALUSrcA  = run & alu_src_a;
  assign Branch   = run & branch;
  assign BranchNe = run & branch_ne;
  assign Illegal  = run & illegal;
  assign ALUSrcB  = {2{run}} & alu_src_b;
  assign ALUOp    = {2{run}} & alu_op;
  assign RegDst   = {2{run}} & reg_dst;
  assign MemtoReg = {2{run}} & mem_to_reg;
  assign PCSrc    = {3{run}} & pc_src;
  assign State    = {5{run}} & state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Scoreboard bench. Stimulus drives one cycle at a time (just after the
//   rising edge) and pushes the hand-computed output word for that cycle.
//   A monitor pops and compares on every falling edge.
//   dut1: MEM_HANDSHAKE=1, ILLEGAL_HALT=1. dut2: MEM_HANDSHAKE=0,
//   ILLEGAL_HALT=0, with MemReady driven to X.
//   Output word: {State[4:0], PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
//                 IorD, ALUSrcA, Branch, BranchNe, Illegal,
//                 ALUSrcB[1:0], ALUOp[1:0], RegDst[1:0], MemtoReg[1:0],
//                 PCSrc[2:0]}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hand-computed expected words
  localparam logic [25:0] E_RST        = 26'd0;
  localparam logic [25:0] E_FETCH_RDY  = {5'd0,  10'b1110000000, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_FETCH_WAIT = {5'd0,  10'b0010000000, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_DECODE     = {5'd1,  10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_MEMADR     = {5'd2,  10'b0000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_MEMRD      = {5'd3,  10'b0010010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_MEMWB      = {5'd4,  10'b0000100000, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0};
  localparam logic [25:0] E_MEMWR      = {5'd5,  10'b0001010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_EXEC       = {5'd6,  10'b0000001000, 2'b00, 2'b10, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_ALUWB      = {5'd7,  10'b0000100000, 2'b00, 2'b00, 2'b01, 2'b00, 3'd0};
  localparam logic [25:0] E_BEQ        = {5'd8,  10'b0000001100, 2'b00, 2'b01, 2'b00, 2'b00, 3'd1};
  localparam logic [25:0] E_BNE        = {5'd8,  10'b0000001110, 2'b00, 2'b01, 2'b00, 2'b00, 3'd1};
  localparam logic [25:0] E_IEX_ADD    = {5'd9,  10'b0000001000, 2'b10, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_IEX_LOG    = {5'd9,  10'b0000001000, 2'b10, 2'b11, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_IWB        = {5'd10, 10'b0000100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0};
  localparam logic [25:0] E_JUMP       = {5'd11, 10'b1000000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd2};
  localparam logic [25:0] E_JR         = {5'd12, 10'b1000000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd4};
  localparam logic [25:0] E_JALR       = {5'd13, 10'b0000100000, 2'b00, 2'b00, 2'b01, 2'b10, 3'd0};
  localparam logic [25:0] E_JAL        = {5'd14, 10'b0000100000, 2'b00, 2'b00, 2'b10, 2'b10, 3'd0};
  localparam logic [25:0] E_TRAP       = {5'd15, 10'b0000000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0};

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  // dut1 signals
  logic       rst1, mr1;
  logic [5:0] op1, fn1;
  logic       pcw1, irw1, mrd1, mwr1, rw1, iord1, sa1, br1, bne1, ill1;
  logic [1:0] sb1, aop1, rd1, m2r1;
  logic [2:0] pcs1;
  logic [4:0] st1;

  // dut2 signals
  logic       rst2, mr2;
  logic [5:0] op2, fn2;
  logic       pcw2, irw2, mrd2, mwr2, rw2, iord2, sa2, br2, bne2, ill2;
  logic [1:0] sb2, aop2, rd2, m2r2;
  logic [2:0] pcs2;
  logic [4:0] st2;

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b1)) dut1 (
    .Clk(Clk), .Reset(rst1), .Op(op1), .Func(fn1), .MemReady(mr1),
    .PCWrite(pcw1), .IRWrite(irw1), .MemRead(mrd1), .MemWrite(mwr1),
    .RegWrite(rw1), .IorD(iord1), .ALUSrcA(sa1), .Branch(br1),
    .BranchNe(bne1), .Illegal(ill1), .ALUSrcB(sb1), .ALUOp(aop1),
    .RegDst(rd1), .MemtoReg(m2r1), .PCSrc(pcs1), .State(st1)
  );

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_HALT(1'b0)) dut2 (
    .Clk(Clk), .Reset(rst2), .Op(op2), .Func(fn2), .MemReady(mr2),
    .PCWrite(pcw2), .IRWrite(irw2), .MemRead(mrd2), .MemWrite(mwr2),
    .RegWrite(rw2), .IorD(iord2), .ALUSrcA(sa2), .Branch(br2),
    .BranchNe(bne2), .Illegal(ill2), .ALUSrcB(sb2), .ALUOp(aop2),
    .RegDst(rd2), .MemtoReg(m2r2), .PCSrc(pcs2), .State(st2)
  );

  logic [25:0] got1, got2;
  assign got1 = {st1, pcw1, irw1, mrd1, mwr1, rw1, iord1, sa1, br1, bne1, ill1,
                 sb1, aop1, rd1, m2r1, pcs1};
  assign got2 = {st2, pcw2, irw2, mrd2, mwr2, rw2, iord2, sa2, br2, bne2, ill2,
                 sb2, aop2, rd2, m2r2, pcs2};

  typedef struct {
    logic [25:0] exp;
    string       name;
  } item_t;

  item_t q1[$];
  item_t q2[$];
  int checks = 0;
  int errors = 0;

  // Monitor: one comparison per pending expectation per falling edge.
  always @(negedge Clk) begin
    item_t it;
    if (q1.size() > 0) begin
      it = q1.pop_front();
      checks++;
      if (got1 !== it.exp) begin
        errors++;
        $display("FAIL dut1 %s: got %h expected %h", it.name, got1, it.exp);
      end else begin
        $display("ok   dut1 %s: %h", it.name, got1);
      end
    end
    if (q2.size() > 0) begin
      it = q2.pop_front();
      checks++;
      if (got2 !== it.exp) begin
        errors++;
        $display("FAIL dut2 %s: got %h expected %h", it.name, got2, it.exp);
      end else begin
        $display("ok   dut2 %s: %h", it.name, got2);
      end
    end
  end

  // Drive one cycle on dut1 and queue its expected outputs.
  task automatic cyc1(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic m, input logic [25:0] e, input string nm);
    item_t it;
    rst1 = r; op1 = o; fn1 = f; mr1 = m;
    it.exp = e; it.name = nm;
    q1.push_back(it);
    @(posedge Clk); #1;
  endtask

  task automatic cyc2(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic m, input logic [25:0] e, input string nm);
    item_t it;
    rst2 = r; op2 = o; fn2 = f; mr2 = m;
    it.exp = e; it.name = nm;
    q2.push_back(it);
    @(posedge Clk); #1;
  endtask

  initial begin
    rst1 = 1'b1; op1 = '0; fn1 = '0; mr1 = 1'b1;
    rst2 = 1'b1; op2 = '0; fn2 = '0; mr2 = 1'bx;
    @(posedge Clk); #1;

    // ---------------- dut1: handshake on, trap halts ----------------
    cyc1(1, OP_LW, 0, 1, E_RST, "reset0");
    cyc1(1, OP_LW, 0, 1, E_RST, "reset1");
    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4,0
    cyc1(0, OP_LW, 0, 1, E_FETCH_RDY, "lw fetch");
    cyc1(0, OP_LW, 0, 1, E_DECODE,    "lw decode");
    cyc1(0, OP_LW, 0, 1, E_MEMADR,    "lw memadr");
    cyc1(0, OP_LW, 0, 0, E_MEMRD,     "lw memrd wait1");
    cyc1(0, OP_LW, 0, 0, E_MEMRD,     "lw memrd wait2");
    cyc1(0, OP_LW, 0, 1, E_MEMRD,     "lw memrd rdy");
    cyc1(0, OP_LW, 0, 1, E_MEMWB,     "lw memwb");
    // lw interrupted by a 2-cycle reset mid-MEMRD
    cyc1(0, OP_LW, 0, 1, E_FETCH_RDY, "lw2 fetch");
    cyc1(0, OP_LW, 0, 1, E_DECODE,    "lw2 decode");
    cyc1(0, OP_LW, 0, 1, E_MEMADR,    "lw2 memadr");
    cyc1(0, OP_LW, 0, 0, E_MEMRD,     "lw2 memrd wait");
    cyc1(1, OP_LW, 0, 0, E_RST,       "reset mid-memrd 0");
    cyc1(1, OP_LW, 0, 0, E_RST,       "reset mid-memrd 1");
    // first post-reset cycle: FETCH, MemRead=1, memory not yet ready
    cyc1(0, OP_BNE, 0, 0, E_FETCH_WAIT, "post-reset fetch wait");
    cyc1(0, OP_BNE, 0, 1, E_FETCH_RDY,  "bne fetch");
    cyc1(0, OP_BNE, 0, 1, E_DECODE,     "bne decode");
    cyc1(0, OP_BNE, 0, 1, E_BNE,        "bne branch");
    cyc1(0, OP_BEQ, 0, 1, E_FETCH_RDY,  "beq fetch");
    cyc1(0, OP_BEQ, 0, 1, E_DECODE,     "beq decode");
    cyc1(0, OP_BEQ, 0, 1, E_BEQ,        "beq branch");
    // jal: 0,1,14,11
    cyc1(0, OP_JAL, 0, 1, E_FETCH_RDY,  "jal fetch");
    cyc1(0, OP_JAL, 0, 1, E_DECODE,     "jal decode");
    cyc1(0, OP_JAL, 0, 1, E_JAL,        "jal link");
    cyc1(0, OP_JAL, 0, 1, E_JUMP,       "jal jump");
    // jalr: 0,1,13,12
    cyc1(0, OP_R, FN_JALR, 1, E_FETCH_RDY, "jalr fetch");
    cyc1(0, OP_R, FN_JALR, 1, E_DECODE,    "jalr decode");
    cyc1(0, OP_R, FN_JALR, 1, E_JALR,      "jalr link");
    cyc1(0, OP_R, FN_JALR, 1, E_JR,        "jalr jr");
    // immediates
    cyc1(0, OP_ORI, 0, 1, E_FETCH_RDY,  "ori fetch");
    cyc1(0, OP_ORI, 0, 1, E_DECODE,     "ori decode");
    cyc1(0, OP_ORI, 0, 1, E_IEX_LOG,    "ori iexec");
    cyc1(0, OP_ORI, 0, 1, E_IWB,        "ori iwb");
    cyc1(0, OP_ADDI, 0, 1, E_FETCH_RDY, "addi fetch");
    cyc1(0, OP_ADDI, 0, 1, E_DECODE,    "addi decode");
    cyc1(0, OP_ADDI, 0, 1, E_IEX_ADD,   "addi iexec");
    cyc1(0, OP_ADDI, 0, 1, E_IWB,       "addi iwb");
    // R-type add
    cyc1(0, OP_R, FN_ADD, 1, E_FETCH_RDY, "add fetch");
    cyc1(0, OP_R, FN_ADD, 1, E_DECODE,    "add decode");
    cyc1(0, OP_R, FN_ADD, 1, E_EXEC,      "add exec");
    cyc1(0, OP_R, FN_ADD, 1, E_ALUWB,     "add aluwb");
    // sw with one wait cycle in MEMWR (MemWrite held)
    cyc1(0, OP_SW, 0, 1, E_FETCH_RDY,   "sw fetch");
    cyc1(0, OP_SW, 0, 1, E_DECODE,      "sw decode");
    cyc1(0, OP_SW, 0, 1, E_MEMADR,      "sw memadr");
    cyc1(0, OP_SW, 0, 0, E_MEMWR,       "sw memwr wait");
    cyc1(0, OP_SW, 0, 1, E_MEMWR,       "sw memwr rdy");
    // j, jr
    cyc1(0, OP_J, 0, 1, E_FETCH_RDY,    "j fetch");
    cyc1(0, OP_J, 0, 1, E_DECODE,       "j decode");
    cyc1(0, OP_J, 0, 1, E_JUMP,         "j jump");
    cyc1(0, OP_R, FN_JR, 1, E_FETCH_RDY, "jr fetch");
    cyc1(0, OP_R, FN_JR, 1, E_DECODE,    "jr decode");
    cyc1(0, OP_R, FN_JR, 1, E_JR,        "jr jr");
    // illegal opcode holds in TRAP until reset
    cyc1(0, OP_BAD, 0, 1, E_FETCH_RDY,  "bad fetch");
    cyc1(0, OP_BAD, 0, 1, E_DECODE,     "bad decode");
    cyc1(0, OP_BAD, 0, 1, E_TRAP,       "trap hold0");
    cyc1(0, OP_BAD, 0, 1, E_TRAP,       "trap hold1");
    cyc1(0, OP_BAD, 0, 1, E_TRAP,       "trap hold2");
    cyc1(1, OP_BAD, 0, 1, E_RST,        "reset from trap");
    cyc1(0, OP_LW, 0, 1, E_FETCH_RDY,   "fetch after trap reset");
    rst1 = 1'b1;

    // ------- dut2: no handshake (MemReady = X), trap lasts one cycle -------
    cyc2(1, OP_BAD, 0, 1'bx, E_RST,       "reset");
    cyc2(0, OP_BAD, 0, 1'bx, E_FETCH_RDY, "bad fetch");
    cyc2(0, OP_BAD, 0, 1'bx, E_DECODE,    "bad decode");
    cyc2(0, OP_BAD, 0, 1'bx, E_TRAP,      "trap pulse");
    cyc2(0, OP_BAD, 0, 1'bx, E_FETCH_RDY, "fetch after trap");
    cyc2(0, OP_BAD, 0, 1'bx, E_DECODE,    "bad2 decode");
    cyc2(0, OP_BAD, 0, 1'bx, E_TRAP,      "trap2 pulse");
    cyc2(0, OP_SW,  0, 1'bx, E_FETCH_RDY, "sw fetch");
    cyc2(0, OP_SW,  0, 1'bx, E_DECODE,    "sw decode");
    cyc2(0, OP_SW,  0, 1'bx, E_MEMADR,    "sw memadr");
    cyc2(0, OP_SW,  0, 1'bx, E_MEMWR,     "sw memwr");
    cyc2(0, OP_LW,  0, 1'bx, E_FETCH_RDY, "fetch after sw");
    rst2 = 1'b1;

    // Let the monitor drain, then confirm nothing was left unchecked.
    repeat (3) @(negedge Clk);
    checks++;
    if (q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
